prog_sequencer: RTL and testbench

//   Upstream run controller for the 9-bit core. Launches programs 1..3 in ascending order
//   per a request mask, drives the core's start and program_num, waits for its done and

---
 rtl/seq_pkg.sv | 26 ++
 rtl/prog_sequencer_if.sv | 27 ++
 rtl/sat_counter.sv | 22 ++
 rtl/prog_sequencer.sv | 117 +++++++++++
 tb/tb_prog_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types for the program sequencer: FSM state encoding, program id type
// and the lowest-pending-program selector.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    RUN,
    REPORT,
    FINISH
  } seq_state_t;

  typedef logic [1:0] prog_id_t;

  localparam prog_id_t PROG_NONE = 2'b00;

  // Programs launch in ascending order, so bit 0 (program 1) wins.
  function automatic prog_id_t lowest_prog(input logic [2:0] mask);
    if (mask[0]) return 2'd1;
    if (mask[1]) return 2'd2;
    if (mask[2]) return 2'd3;
    return PROG_NONE;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Core launch handshake plus result stream between the sequencer (master)
// and the core / result consumer (slave).
interface prog_sequencer_if #(
  parameter int CYC_WIDTH = 16
);
  import seq_pkg::*;

  logic                 core_start;
  prog_id_t             core_prog;
  logic                 core_done;
  logic                 res_valid;
  logic                 res_ready;
  prog_id_t             res_prog;
  logic [CYC_WIDTH-1:0] res_cycles;
  logic                 res_timeout;

  modport master (
    output core_start, core_prog, res_valid, res_prog, res_cycles, res_timeout,
    input  core_done, res_ready
  );

  modport slave (
    input  core_start, core_prog, res_valid, res_prog, res_cycles, res_timeout,
    output core_done, res_ready
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: launches the requested programs in ascending order, times
// each one on a shared counter and streams one result per program.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int CYC_WIDTH    = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_req,
  input  logic [2:0]       prog_mask,
  input  logic             abort,
  output logic             busy,
  output logic             seq_done,
  prog_sequencer_if.master bus
);

  localparam logic [CYC_WIDTH-1:0] START_LAST   = CYC_WIDTH'(START_CYCLES - 1);
  localparam logic [CYC_WIDTH-1:0] TIMEOUT_LAST = CYC_WIDTH'(TIMEOUT - 1);
  localparam logic [CYC_WIDTH-1:0] TIMEOUT_VAL  = CYC_WIDTH'(TIMEOUT);

  seq_state_t           state;
  seq_state_t           state_next;
  logic [2:0]           pending;
  prog_id_t             core_prog;
  logic [CYC_WIDTH-1:0] count;
  logic                 cnt_clear;
  logic                 cnt_enable;
  logic                 done_hit;
  logic                 timeout_hit;
  logic                 abort_hit;
  prog_id_t             res_prog;
  logic [CYC_WIDTH-1:0] res_cycles;
  logic                 res_timeout;

  // One counter times both the start pulse and the run; it restarts on entry to each.
  sat_counter #(
    .WIDTH(CYC_WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (count)
  );

  assign cnt_clear   = (state == SELECT) || ((state == START) && (count == START_LAST));
  assign cnt_enable  = (state == START) || (state == RUN);
  assign done_hit    = (state == RUN) && bus.core_done;
  assign timeout_hit = (state == RUN) && !bus.core_done && (count == TIMEOUT_LAST);
  assign abort_hit   = abort && (state != IDLE) && (state != FINISH);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run_req) state_next = SELECT;
      SELECT:  state_next = (pending == 3'd0) ? FINISH : START;
      START:   if (count == START_LAST) state_next = RUN;
      RUN:     if (done_hit || timeout_hit) state_next = REPORT;
      REPORT:  if (bus.res_ready) state_next = SELECT;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = FINISH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= 3'd0;
      core_prog   <= PROG_NONE;
      res_prog    <= PROG_NONE;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_next;

      if ((state == IDLE) && run_req) begin
        pending <= prog_mask;
      end else if (state_next == FINISH) begin
        pending <= 3'd0;
      end else if ((state == SELECT) && (pending != 3'd0)) begin
        pending <= pending & (pending - 3'd1);
      end

      if (state_next == FINISH) begin
        core_prog <= PROG_NONE;
      end else if ((state == SELECT) && (pending != 3'd0)) begin
        core_prog <= lowest_prog(pending);
      end

      // A done in the final timeout cycle still counts as a normal completion.
      if ((state == RUN) && (state_next == REPORT)) begin
        res_prog <= core_prog;
        if (done_hit) begin
          res_cycles  <= count;
          res_timeout <= 1'b0;
        end else begin
          res_cycles  <= TIMEOUT_VAL;
          res_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.core_start  = (state == START);
  assign bus.core_prog   = core_prog;
  assign bus.res_valid   = (state == REPORT);
  assign bus.res_prog    = res_prog;
  assign bus.res_cycles  = res_cycles;
  assign bus.res_timeout = res_timeout;
  assign busy            = (state != IDLE);
  assign seq_done        = (state == FINISH);

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: vector table, random runs against a
// per-program result model, and hand-written hold/abort/reset/empty sequences.
module tb_prog_sequencer;

  localparam int START_CYCLES = 2;
  localparam int CYC_WIDTH    = 16;
  localparam int TIMEOUT      = 4096;
  localparam int WAIT_BOUND   = 20000;

  typedef struct {
    int prog;
    int cycles;
    int timeout;
  } res_t;

  typedef struct {
    logic [2:0] mask;
    int         d1;
    int         d2;
    int         d3;
    int         ready;
    int         exp_results;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run_req;
  logic       abort;
  logic [2:0] prog_mask;
  logic       busy;
  logic       seq_done;

  prog_sequencer_if #(.CYC_WIDTH(CYC_WIDTH)) bus ();

  prog_sequencer #(
    .START_CYCLES (START_CYCLES),
    .CYC_WIDTH    (CYC_WIDTH),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_req   (run_req),
    .prog_mask (prog_mask),
    .abort     (abort),
    .busy      (busy),
    .seq_done  (seq_done),
    .bus       (bus)
  );

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   n_results    = 0;
  int   n_starts     = 0;
  int   n_seq_done   = 0;
  int   ready_mode   = 1;
  int   done_delay [4];
  res_t exp_q [$];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Expected results follow directly from the rules: ascending programs, done
  // delay reported as-is if it lands before the timeout, otherwise TIMEOUT.
  function automatic void modelResults(input logic [2:0] mask);
    res_t r;
    for (int p = 1; p <= 3; p++) begin
      if (mask[p-1]) begin
        r.prog = p;
        if (done_delay[p] >= 0 && done_delay[p] < TIMEOUT) begin
          r.cycles  = done_delay[p];
          r.timeout = 0;
        end else begin
          r.cycles  = TIMEOUT;
          r.timeout = 1;
        end
        exp_q.push_back(r);
      end
    end
  endfunction

  // Core model: raises done a programmable number of cycles after start release.
  initial begin : core_model
    int run_cnt;
    int cur_prog;
    bit running;
    run_cnt       = 0;
    cur_prog      = 0;
    running       = 1'b0;
    bus.core_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        running       = 1'b0;
        bus.core_done = 1'b0;
      end else if (bus.core_start) begin
        running       = 1'b1;
        run_cnt       = 0;
        cur_prog      = int'(bus.core_prog);
        bus.core_done = 1'b0;
      end else if (running) begin
        if (run_cnt == done_delay[cur_prog]) bus.core_done = 1'b1;
        run_cnt++;
      end
    end
  end

  initial begin : ready_driver
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.res_ready = 1'b0;
        1:       bus.res_ready = 1'b1;
        default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    int start_len;
    bit hold_pending;
    start_len    = 0;
    hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        start_len    = 0;
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) checkOutput("res_valid held until transfer", int'(bus.res_valid), 1);
        if (bus.res_valid) begin
          checkOutput("result expected by model", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            checkOutput("res_prog", int'(bus.res_prog), exp_q[0].prog);
            checkOutput("res_cycles", int'(bus.res_cycles), exp_q[0].cycles);
            checkOutput("res_timeout", int'(bus.res_timeout), exp_q[0].timeout);
            if (bus.res_ready) exp_q.delete(0);
          end
          if (bus.res_ready) n_results++;
        end
        hold_pending = bus.res_valid && !bus.res_ready && !abort;
        if (bus.core_start) begin
          start_len++;
        end else if (start_len != 0) begin
          checkOutput("core_start length", start_len, START_CYCLES);
          start_len = 0;
          n_starts++;
        end
        if (seq_done) n_seq_done++;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] mask);
    @(posedge clk);
    #1;
    run_req   = 1'b1;
    prog_mask = mask;
    @(posedge clk);
    #1;
    run_req   = 1'b0;
    prog_mask = 3'($urandom_range(0, 7));
  endtask

  task automatic waitSeqDone(input string name);
    int k;
    k = 0;
    while (!seq_done && k < WAIT_BOUND) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, int'(seq_done), 1);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int res0;
    int st0;
    int sd0;
    res0 = n_results;
    st0  = n_starts;
    sd0  = n_seq_done;
    done_delay[1] = v.d1;
    done_delay[2] = v.d2;
    done_delay[3] = v.d3;
    ready_mode    = v.ready;
    modelResults(v.mask);
    applyStimulus(v.mask);
    waitSeqDone({tag, " seq_done"});
    @(posedge clk);
    #1;
    checkOutput({tag, " busy idle"}, int'(busy), 0);
    @(negedge clk);
    checkOutput({tag, " results"}, n_results - res0, v.exp_results);
    checkOutput({tag, " launches"}, n_starts - st0, $countones(v.mask));
    checkOutput({tag, " seq_done pulses"}, n_seq_done - sd0, 1);
    checkOutput({tag, " model drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : stimulus
    vec_t vecs [5];
    vec_t rv;
    int   res0;
    int   st0;
    int   sd0;
    int   k;

    vecs[0] = '{3'b111, 80, 158, 236, 1, 3};
    vecs[1] = '{3'b100, -1, -1, -1, 1, 1};
    vecs[2] = '{3'b000, 5, 5, 5, 1, 0};
    vecs[3] = '{3'b101, 0, 7, 4095, 2, 2};
    vecs[4] = '{3'b010, 0, 4096, 0, 2, 1};

    for (int i = 0; i < 4; i++) done_delay[i] = -1;
    run_req   = 1'b0;
    abort     = 1'b0;
    prog_mask = 3'b000;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset core_start", int'(bus.core_start), 0);
    checkOutput("reset core_prog", int'(bus.core_prog), 0);
    checkOutput("reset res_valid", int'(bus.res_valid), 0);
    checkOutput("reset res_cycles", int'(bus.res_cycles), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset seq_done", int'(seq_done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Empty mask: seq_done two cycles after the request, nothing launched.
    st0 = n_starts;
    sd0 = n_seq_done;
    applyStimulus(3'b000);
    checkOutput("empty busy in select", int'(busy), 1);
    checkOutput("empty seq_done early", int'(seq_done), 0);
    @(posedge clk);
    #1;
    checkOutput("empty seq_done", int'(seq_done), 1);
    @(posedge clk);
    #1;
    checkOutput("empty busy after", int'(busy), 0);
    checkOutput("empty seq_done width", int'(seq_done), 0);
    @(negedge clk);
    checkOutput("empty launches", n_starts - st0, 0);
    checkOutput("empty seq_done pulses", n_seq_done - sd0, 1);

    // Abort while idle does nothing.
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("idle abort busy", int'(busy), 0);
    checkOutput("idle abort seq_done", int'(seq_done), 0);

    // Backpressure: first result must sit unchanged, program 2 must wait.
    done_delay[1] = 20;
    done_delay[2] = 30;
    done_delay[3] = -1;
    res0 = n_results;
    st0  = n_starts;
    @(negedge clk) ready_mode = 0;
    modelResults(3'b011);
    applyStimulus(3'b011);
    k = 0;
    while (!bus.res_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput("hold reached report", int'(bus.res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold res_valid", int'(bus.res_valid), 1);
      checkOutput("hold res_prog", int'(bus.res_prog), 1);
      checkOutput("hold res_cycles", int'(bus.res_cycles), 20);
      checkOutput("hold res_timeout", int'(bus.res_timeout), 0);
      checkOutput("hold core_prog", int'(bus.core_prog), 1);
      checkOutput("hold core_start", int'(bus.core_start), 0);
      @(negedge clk);
    end
    ready_mode = 1;
    waitSeqDone("hold seq_done");
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("hold results", n_results - res0, 2);
    checkOutput("hold launches", n_starts - st0, 2);
    checkOutput("hold model drained", exp_q.size(), 0);
    exp_q.delete();

    // Abort during program 2: only program 1 reports.
    done_delay[1] = 30;
    done_delay[2] = 200;
    done_delay[3] = 30;
    ready_mode    = 1;
    res0 = n_results;
    st0  = n_starts;
    sd0  = n_seq_done;
    modelResults(3'b001);
    applyStimulus(3'b111);
    k = 0;
    while (!(bus.core_prog == 2'd2 && !bus.core_start) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort reached prog2 run", int'(k < 2000), 1);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort core_start", int'(bus.core_start), 0);
    checkOutput("abort res_valid", int'(bus.res_valid), 0);
    checkOutput("abort seq_done", int'(seq_done), 1);
    checkOutput("abort core_prog", int'(bus.core_prog), 0);
    @(posedge clk);
    #1;
    checkOutput("abort busy after", int'(busy), 0);
    @(negedge clk);
    checkOutput("abort results", n_results - res0, 1);
    checkOutput("abort launches", n_starts - st0, 2);
    checkOutput("abort seq_done pulses", n_seq_done - sd0, 1);
    checkOutput("abort model drained", exp_q.size(), 0);
    exp_q.delete();
    rv = '{3'b011, 12, 25, 0, 1, 2};
    runVector(rv, "after abort");

    // Asynchronous reset in the middle of a run.
    done_delay[1] = 50;
    done_delay[2] = 60;
    done_delay[3] = 70;
    ready_mode    = 1;
    modelResults(3'b111);
    applyStimulus(3'b111);
    k = 0;
    while (!(bus.core_prog == 2'd1 && !bus.core_start) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reset reached run", int'(k < 200), 1);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midrun reset core_start", int'(bus.core_start), 0);
    checkOutput("midrun reset core_prog", int'(bus.core_prog), 0);
    checkOutput("midrun reset res_valid", int'(bus.res_valid), 0);
    checkOutput("midrun reset res_prog", int'(bus.res_prog), 0);
    checkOutput("midrun reset res_cycles", int'(bus.res_cycles), 0);
    checkOutput("midrun reset res_timeout", int'(bus.res_timeout), 0);
    checkOutput("midrun reset busy", int'(busy), 0);
    checkOutput("midrun reset seq_done", int'(seq_done), 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    rv = '{3'b110, 0, 40, 9, 1, 2};
    runVector(rv, "after reset");

    for (int r = 0; r < 6; r++) begin
      rv.mask        = 3'($urandom_range(0, 7));
      rv.d1          = int'($urandom_range(0, 400));
      rv.d2          = int'($urandom_range(0, 400));
      rv.d3          = int'($urandom_range(0, 400));
      rv.ready       = 2;
      rv.exp_results = $countones(rv.mask);
      runVector(rv, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
